openram_scan_driver: RTL and testbench

//  Upstream GPIO-side sequencer for the SRAM test-chip instruction register.
//  - Accepts one 112-bit instruction word over a valid/ready interface.
//  - Serialises it into the test-chip scan register, waits for the SRAM

---
 rtl/openram_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_openram_scan_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/openram_scan_driver.sv
// Scans one 112-bit instruction into the SRAM test chip, pulses load, then shifts both 32-bit read words back out.
// Accept to rsp_valid is 148 cycles and the response is held until rsp_ready. OPENRAM_SCAN_WRSKIP_EN skips read-back for all-write commands.
module openram_scan_driver #(
  parameter int CMD_W     = 112,
  parameter int DATA_W    = 32,
  parameter int SRAM_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_word,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data0,
  output logic [DATA_W-1:0] rsp_data1,
  output logic              busy,
  output logic              gpio_bit,
  output logic              gpio_in_scan,
  output logic              gpio_sram_load,
  output logic              gpio_out_scan,
  input  logic              gpio_data0,
  input  logic              gpio_data1
);

  localparam int CNT_W    = 7;
  localparam int DIDX_W   = $clog2(DATA_W);
  localparam int WEB0_BIT = 58;
  localparam int WEB1_BIT = 4;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SRAM_WAIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT_OUT,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  shadow_q, shadow_d;
  logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic              gpio_bit_q, gpio_bit_d;
  logic              gpio_in_scan_q, gpio_in_scan_d;
  logic              gpio_sram_load_q, gpio_sram_load_d;
  logic              gpio_out_scan_q, gpio_out_scan_d;
  logic [CNT_W-1:0]  bit_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          shadow_d = cmd_word;
          cnt_d    = '0;
          state_d  = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        if (cnt_q == CMD_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
`ifdef OPENRAM_SCAN_WRSKIP_EN
          // Both ports writing: nothing to read back, answer with zeros.
          if (!shadow_q[WEB0_BIT] && !shadow_q[WEB1_BIT]) begin
            rsp_data0_d = '0;
            rsp_data1_d = '0;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_LOAD;
          end
`else
          state_d = ST_LOAD;
`endif
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        // Taps are sampled on the same edge that shifts the chip register.
        rsp_data0_d[cnt_q[DIDX_W-1:0]] = gpio_data0;
        rsp_data1_d[cnt_q[DIDX_W-1:0]] = gpio_data1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    bit_idx          = CMD_LAST - cnt_d;
    cmd_ready_d      = (state_d == ST_IDLE);
    busy_d           = (state_d != ST_IDLE);
    rsp_valid_d      = (state_d == ST_RESP);
    gpio_in_scan_d   = (state_d == ST_SHIFT_IN);
    gpio_bit_d       = gpio_in_scan_d & shadow_d[bit_idx];
    gpio_sram_load_d = (state_d == ST_LOAD);
    gpio_out_scan_d  = (state_d == ST_SHIFT_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      shadow_q         <= '0;
      rsp_data0_q      <= '0;
      rsp_data1_q      <= '0;
      // Idle is ready, so ready reads high from the moment reset asserts.
      cmd_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
      gpio_bit_q       <= 1'b0;
      gpio_in_scan_q   <= 1'b0;
      gpio_sram_load_q <= 1'b0;
      gpio_out_scan_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      shadow_q         <= shadow_d;
      rsp_data0_q      <= rsp_data0_d;
      rsp_data1_q      <= rsp_data1_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      busy_q           <= busy_d;
      gpio_bit_q       <= gpio_bit_d;
      gpio_in_scan_q   <= gpio_in_scan_d;
      gpio_sram_load_q <= gpio_sram_load_d;
      gpio_out_scan_q  <= gpio_out_scan_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data0      = rsp_data0_q;
  assign rsp_data1      = rsp_data1_q;
  assign busy           = busy_q;
  assign gpio_bit       = gpio_bit_q;
  assign gpio_in_scan   = gpio_in_scan_q;
  assign gpio_sram_load = gpio_sram_load_q;
  assign gpio_out_scan  = gpio_out_scan_q;

endmodule

// File: tb/tb_openram_scan_driver.sv
// Bench for openram_scan_driver: test-chip scan register model, cycle-offset reference model, directed and random commands.
module tb_openram_scan_driver;
  localparam int CMD_W     = 112;
  localparam int DATA_W    = 32;
  localparam int SRAM_WAIT = 2;
`ifdef OPENRAM_SCAN_WRSKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              rsp_ready = 1'b0;
  logic [CMD_W-1:0]  cmd_word = '0;
  logic              cmd_ready, rsp_valid, busy;
  logic              gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan;
  logic              gpio_data0, gpio_data1;
  logic [DATA_W-1:0] rsp_data0, rsp_data1;

  logic [CMD_W-1:0]  chip = '0;
  logic [DATA_W-1:0] rd0 = '0, rd1 = '0;
  int n_chk = 0, n_pass = 0, cyc = 0, n_load = 0;

  always #5 clk = ~clk;

  openram_scan_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .busy(busy),
    .gpio_bit(gpio_bit), .gpio_in_scan(gpio_in_scan), .gpio_sram_load(gpio_sram_load),
    .gpio_out_scan(gpio_out_scan), .gpio_data0(gpio_data0), .gpio_data1(gpio_data1)
  );

  // Test-chip register: left shift on scan-in, read words at [91:60]/[37:6], right shift on scan-out.
  assign gpio_data0 = chip[60];
  assign gpio_data1 = chip[6];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gpio_sram_load) n_load <= n_load + 1;
    if (gpio_in_scan) chip <= {chip[CMD_W-2:0], gpio_bit};
    else if (gpio_sram_load) begin
      chip[91:60] <= rd0;
      chip[37:6]  <= rd1;
    end else if (gpio_out_scan) chip <= {1'b0, chip[CMD_W-1:1]};
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int resp_at(input bit s);
    return s ? CMD_W + SRAM_WAIT + 1 : CMD_W + SRAM_WAIT + 1 + DATA_W + 1;
  endfunction

  // Reference model: t is the current cycle's offset from the accept cycle (accept cycle = 0).
  logic              m_busy = 1'b0, m_skip = 1'b0;
  int                t = 0;
  logic [CMD_W-1:0]  m_cmd = '0;
  logic [DATA_W-1:0] m_rd0 = '0, m_rd1 = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      t      <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1;
        t      <= 1;
        m_cmd  <= cmd_word;
        m_rd0  <= rd0;
        m_rd1  <= rd1;
        m_skip <= SKIP_ON && !cmd_word[58] && !cmd_word[4];
      end
    end else if (t >= resp_at(m_skip) && rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      t <= t + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [6:0] exp_o;
    bit in_s, ld, os, rv;
    if (!m_busy) begin
      exp_o = 7'b1000000;
      rv = 1'b0;
    end else begin
      in_s  = (t <= CMD_W);
      ld    = !m_skip && t == CMD_W + SRAM_WAIT + 1;
      os    = !m_skip && t > CMD_W + SRAM_WAIT + 1 && t <= CMD_W + SRAM_WAIT + 1 + DATA_W;
      rv    = t >= resp_at(m_skip);
      exp_o = {1'b0, 1'b1, rv, in_s ? m_cmd[CMD_W-t] : 1'b0, in_s, ld, os};
    end
    check("outputs{rdy,busy,rvld,bit,in,ld,out}",
          {cmd_ready, busy, rsp_valid, gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan}, exp_o);
    if (rv) begin
      check("rsp_data0", rsp_data0, m_skip ? '0 : m_rd0);
      check("rsp_data1", rsp_data1, m_skip ? '0 : m_rd1);
    end
    if (m_busy && t == CMD_W + 1) check("scan_image", chip, m_cmd);
  end

  // Callers sit 1 time unit after a rising edge.
  task automatic issue(input logic [CMD_W-1:0] w, output int acc);
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_word  = w;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int acc, input int exp_lat, input int hold,
                            output logic [DATA_W-1:0] g0, output logic [DATA_W-1:0] g1);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_valid_wait", rsp_valid, 1'b1);
    check("latency", cyc - acc + 1, exp_lat);
    g0 = rsp_data0;
    g1 = rsp_data1;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_vld_rdy", {rsp_valid, cmd_ready}, 2'b10);
      check("hold_data", {rsp_data0, rsp_data1}, {g0, g1});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("release_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic run_cmd(input logic [CMD_W-1:0] w, input logic [DATA_W-1:0] r0, input logic [DATA_W-1:0] r1,
                         input int hold, input bit poke,
                         output logic [DATA_W-1:0] g0, output logic [DATA_W-1:0] g1);
    int a;
    int lat;
    rd0 = r0;
    rd1 = r1;
    lat = (SKIP_ON && !w[58] && !w[4]) ? 115 : 148;
    issue(w, a);
    if (poke) begin
      repeat (125) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_word  = ~w;
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    finish_rsp(a, lat, hold, g0, g1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [CMD_W-1:0]  w;
    logic [127:0]      rnd;
    logic [DATA_W-1:0] g0, g1, r0, r1;
    int a, loads;

    reset = 1'b1;
    #2;
    check("reset_outputs", {cmd_ready, busy, rsp_valid, gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan}, 7'b1000000);
    check("reset_rsp", {rsp_data0, rsp_data1}, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid scan-in (cnt = 50), then a clean command.
    w = '0; w[58] = 1'b1; w[4] = 1'b1; w[111:108] = 4'h5; w[33:2] = 32'hCAFE_F00D;
    rd0 = 32'h1111_2222; rd1 = 32'h3333_4444;
    issue(w, a);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {cmd_ready, busy, rsp_valid, gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan}, 7'b1000000);
    @(posedge clk); #1 reset = 1'b0;
    run_cmd(w, 32'h5555_6666, 32'h7777_8888, 0, 1'b0, g0, g1);
    check("after_reset_data0", g0, 32'h5555_6666);

    // Scan-in order against the chip register image.
    w = 112'h1_0000_A5A5A5A5_000000000000000;
    rd0 = 32'h0; rd1 = 32'h0;
    issue(w, a);
    repeat (112) @(posedge clk);
    #1;
    check("scan_in_literal", chip, 112'h1_0000_A5A5A5A5_000000000000000);
    finish_rsp(a, SKIP_ON ? 115 : 148, 0, g0, g1);

    // Plain read with literal read words.
    w = '0; w[58] = 1'b1; w[4] = 1'b1;
    run_cmd(w, 32'hDEADBEEF, 32'h01234567, 0, 1'b0, g0, g1);
    check("read_data0", g0, 32'hDEADBEEF);
    check("read_data1", g1, 32'h01234567);

    // Back-pressure for 20 cycles.
    run_cmd(w, 32'hA0A0_0505, 32'h0F0F_F0F0, 20, 1'b0, g0, g1);
    check("bp_data1", g1, 32'h0F0F_F0F0);

    // Command pulsed during SHIFT_OUT is ignored.
    run_cmd(w, 32'h8000_0001, 32'h7FFF_FFFE, 1, 1'b1, g0, g1);
    check("ignored_cmd_data0", g0, 32'h8000_0001);
    check("ignored_cmd_data1", g1, 32'h7FFF_FFFE);

    // Both ports write, chip select 3.
    w = '0; w[111:108] = 4'h3;
    loads = n_load;
    run_cmd(w, 32'h1357_9BDF, 32'h2468_ACE0, 0, 1'b0, g0, g1);
    check("wr_load_pulses", n_load - loads, SKIP_ON ? 0 : 1);
    check("wr_rsp", {g0, g1}, SKIP_ON ? 64'h0 : 64'h1357_9BDF_2468_ACE0);

    // Random commands, read words and hold times.
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      w = rnd[CMD_W-1:0];
      w[58] = 1'($urandom_range(0, 1));
      w[4]  = 1'($urandom_range(0, 1));
      r0 = $urandom;
      r1 = $urandom;
      run_cmd(w, r0, r1, $urandom_range(0, 3), 1'b0, g0, g1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
